// File: rtl/data_mem_banked.sv
// -----------------------------------------------------------------------------
// data_mem_banked
//
// Byte-addressable data memory built from four 8-bit lanes (little-endian),
// serving one RV32I load/store at a time through a small request/response
// handshake. Sub-word loads are sign- or zero-extended. Accesses that straddle
// a word boundary are either split into two word accesses or rejected,
// depending on the build.
//
// Build option:
//   DATA_MEM_MISALIGN_SPLIT_EN  defined   : boundary-crossing H/HU/W accesses
//                                           are performed as two word accesses
//                                           (LO then HI).
//                               undefined : any misaligned H/HU or W access is
//                                           rejected with resp_err; HI is never
//                                           entered.
//
// Parameters:
//   ADDR_W       byte-address width
//   DEPTH_WORDS  number of 32-bit words (power of two); addresses wrap modulo
//                4*DEPTH_WORDS
//
// Ports:
//   clk         single clock, rising edge
//   rst         asynchronous active-high reset (control state only; memory
//               contents are kept)
//   req_valid   request present
//   req_ready   request can be accepted (IDLE only)
//   req_we      1 = store, 0 = load
//   req_func3   width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr    byte address
//   req_wdata   store data, LSB-aligned
//   resp_valid  one-cycle completion pulse
//   resp_rdata  load result (0 for stores and rejected requests)
//   resp_err    request rejected, qualified by resp_valid
// -----------------------------------------------------------------------------
module data_mem_banked #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int LA_W  = IDX_W + 2;

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

  // control state (reset)
  state_t      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  // latched request and low-word capture (no reset)
  logic            we_q, we_d;
  logic [2:0]      func3_q, func3_d;
  logic [LA_W-1:0] addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     lo_word_q, lo_word_d;

  // four byte-wide banks, one per lane
  logic [7:0] lane_mem [4][DEPTH_WORDS];

  // Upper address bits select nothing: the array wraps.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr;

  // ---------------------------------------------------------------------------
  // request decode (from latched fields)
  // ---------------------------------------------------------------------------
  logic [1:0]       off;
  logic [IDX_W-1:0] idx, idx_nxt, acc_idx;
  logic             is_h, is_w, bad_code, illegal, split_go;

  assign off     = addr_q[1:0];
  assign idx     = addr_q[LA_W-1:2];
  assign idx_nxt = idx + IDX_W'(1);
  assign is_h    = (func3_q[1:0] == 2'b01);
  assign is_w    = (func3_q[1:0] == 2'b10);

  // Reserved codes, and unsigned widths used with a store.
  assign bad_code = (func3_q == 3'b011) || (func3_q[2:1] == 2'b11) ||
                    (we_q && func3_q[2]);

`ifdef DATA_MEM_MISALIGN_SPLIT_EN
  logic crossing;
  assign crossing = (is_h && (off == 2'b11)) || (is_w && (off != 2'b00));
  assign illegal  = bad_code;
  assign split_go = crossing;
`else
  logic misaligned;
  assign misaligned = (is_h && off[0]) || (is_w && (off != 2'b00));
  assign illegal    = bad_code || misaligned;
  assign split_go   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // lane steering: a 64-bit view spanning word idx (low) and idx+1 (high)
  // ---------------------------------------------------------------------------
  logic [3:0]  size_mask;
  logic [7:0]  be_wide;
  logic [63:0] wd_wide;
  logic        in_hi;
  logic [3:0]  lane_be, lane_we;
  logic [31:0] lane_wd;
  logic [31:0] rd_word;
  logic [63:0] ld_raw;
  logic [31:0] ld_aligned, ld_result;

  always_comb begin
    case (func3_q[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  assign be_wide = {4'b0000, size_mask} << off;
  assign wd_wide = {32'h0, wdata_q} << {off, 3'b000};
  assign in_hi   = (state_q == HI);
  assign acc_idx = in_hi ? idx_nxt : idx;
  assign lane_be = in_hi ? be_wide[7:4] : be_wide[3:0];
  assign lane_wd = in_hi ? wd_wide[63:32] : wd_wide[31:0];
  assign lane_we = lane_be & {4{((state_q == LO) || in_hi) && we_q && !illegal}};

  assign rd_word = {lane_mem[3][acc_idx], lane_mem[2][acc_idx],
                    lane_mem[1][acc_idx], lane_mem[0][acc_idx]};

  // In HI the first-word capture sits below the second word, so one right
  // shift by the byte offset lines the requested bytes up at bit 0.
  assign ld_raw     = in_hi ? {rd_word, lo_word_q} : {32'h0, rd_word};
  assign ld_aligned = 32'(ld_raw >> {off, 3'b000});
  assign ld_result  = load_extend(ld_aligned, func3_q);

  function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                              input logic [2:0]  f3);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    b = raw[7:0];
    h = raw[15:0];
    case (f3)
      3'b000:  ext = 32'(b);
      3'b001:  ext = 32'(h);
      3'b100:  ext = signed'({24'h0, raw[7:0]});
      3'b101:  ext = signed'({16'h0, raw[15:0]});
      default: ext = signed'(raw);
    endcase
    return unsigned'(ext);
  endfunction

  // ---------------------------------------------------------------------------
  // next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    we_d         = we_q;
    func3_d      = func3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    lo_word_d    = lo_word_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          we_d    = req_we;
          func3_d = req_func3;
          addr_d  = req_addr[LA_W-1:0];
          wdata_d = req_wdata;
          state_d = LO;
        end
      end
      LO: begin
        if (illegal) begin
          resp_err_d   = 1'b1;
          resp_rdata_d = 32'h0;
          state_d      = RESP;
        end else if (split_go) begin
          lo_word_d = rd_word;
          state_d   = HI;
        end else begin
          resp_err_d   = 1'b0;
          resp_rdata_d = we_q ? 32'h0 : ld_result;
          state_d      = RESP;
        end
      end
      HI: begin
        resp_err_d   = 1'b0;
        resp_rdata_d = we_q ? 32'h0 : ld_result;
        state_d      = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered copies of the state being entered.
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
  end

  // ---------------------------------------------------------------------------
  // control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // request/data registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    we_q      <= we_d;
    func3_q   <= func3_d;
    addr_q    <= addr_d;
    wdata_q   <= wdata_d;
    lo_word_q <= lo_word_d;
  end

  // ---------------------------------------------------------------------------
  // memory banks
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (lane_we[l]) lane_mem[l][acc_idx] <= lane_wd[8*l +: 8];
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_data_mem_banked.sv
// -----------------------------------------------------------------------------
// tb_data_mem_banked
//
// Directed and randomized load/store sequence for data_mem_banked. Expected
// responses are queued as each request is driven and popped when resp_valid
// appears. A byte-array reference memory supplies expectations for the
// randomized phase. Follows DATA_MEM_MISALIGN_SPLIT_EN if defined.
// -----------------------------------------------------------------------------
module tb_data_mem_banked;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  lat;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] mdl [256];
  logic [2:0] f3_tab [10] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101,
                              3'b000, 3'b001, 3'b010, 3'b011, 3'b110};

  always #5 clk = ~clk;

  data_mem_banked #(
    .ADDR_W      (32),
    .DEPTH_WORDS (64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_func3  (req_func3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int mdl_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic mdl_illegal(input logic we, input logic [2:0] f3,
                                       input logic [7:0] a);
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
    if (we && (f3 == 3'b100 || f3 == 3'b101)) return 1'b1;
`ifndef DATA_MEM_MISALIGN_SPLIT_EN
    if ((f3 == 3'b001 || f3 == 3'b101) && a[0]) return 1'b1;
    if (f3 == 3'b010 && a[1:0] != 2'b00) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic mdl_write(input logic [7:0] a, input logic [2:0] f3, input logic [31:0] wd);
    for (int k = 0; k < mdl_size(f3); k++) mdl[8'(a + k)] = wd[8*k +: 8];
  endtask

  function automatic logic [31:0] mdl_load(input logic [7:0] a, input logic [2:0] f3);
    logic [31:0] v;
    v = {mdl[8'(a + 3)], mdl[8'(a + 2)], mdl[8'(a + 1)], mdl[a]};
    case (f3)
      3'b000:  return {{24{v[7]}}, v[7:0]};
      3'b100:  return {24'h0, v[7:0]};
      3'b001:  return {{16{v[15]}}, v[15:0]};
      3'b101:  return {16'h0, v[15:0]};
      default: return v;
    endcase
  endfunction

  task automatic mdl_expect(input logic we, input logic [2:0] f3, input logic [7:0] a,
                            output logic [31:0] er, output logic ee, output int el);
    if (mdl_illegal(we, f3, a)) begin
      er = 32'h0; ee = 1'b1; el = 2;
    end else begin
      ee = 1'b0;
      el = ((int'(a[1:0]) + mdl_size(f3)) > 4) ? 3 : 2;
      er = we ? 32'h0 : mdl_load(a, f3);
    end
  endtask

  // ---------------- one transaction ----------------
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee, input int el);
    exp_t e;
    exp_t x;
    int   n;
    int   lat;
    logic seen;
    e.rdata = er; e.err = ee; e.lat = 4'(el);
    sb_q.push_back(e);
    if (we && !ee) mdl_write(addr[7:0], f3, wd);

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = addr; req_wdata = wd;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_ready"}, req_ready, 1'b1);
    @(posedge clk);
    #1;
    // Scramble the request bus after acceptance; the DUT must use its latch.
    req_valid = 1'b0; req_we = ~we; req_func3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;

    lat = 0; seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (resp_valid === 1'b1) seen = 1'b1;
    end
    chk({tag, "_resp_seen"}, seen, 1'b1);
    x = sb_q.pop_front();
    if (seen) begin
      chk({tag, "_rdata"}, resp_rdata, x.rdata);
      chk({tag, "_err"}, resp_err, x.err);
      chk({tag, "_lat"}, lat, 32'(x.lat));
    end
    @(negedge clk);
    chk({tag, "_pulse"}, resp_valid, 1'b0);
    chk({tag, "_idle_ready"}, req_ready, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int          n;
    logic        seen;
    logic [2:0]  f3;
    logic        we;
    logic [31:0] a, wd, er;
    logic        ee;
    int          el;

    for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_rvalid", resp_valid, 1'b0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", resp_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1'b1);

    // aligned word
    do_req("sw10", 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2);
    do_req("lw10", 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2);

    // sub-word
    do_req("sw20", 1, 3'b010, 32'h20, 32'h0, 32'h0, 0, 2);
    do_req("sb21", 1, 3'b000, 32'h21, 32'h12345680, 32'h0, 0, 2);
    do_req("lb21", 0, 3'b000, 32'h21, 32'h0, 32'hFFFFFF80, 0, 2);
    do_req("lbu21", 0, 3'b100, 32'h21, 32'h0, 32'h00000080, 0, 2);
    do_req("lh20", 0, 3'b001, 32'h20, 32'h0, 32'hFFFF8000, 0, 2);
    do_req("lhu20", 0, 3'b101, 32'h20, 32'h0, 32'h00008000, 0, 2);
    do_req("lw20", 0, 3'b010, 32'h20, 32'h0, 32'h00008000, 0, 2);

    // illegal codes
    do_req("f3_011", 0, 3'b011, 32'h20, 32'h0, 32'h0, 1, 2);
    do_req("sbu_st", 1, 3'b100, 32'h20, 32'hFFFFFFFF, 32'h0, 1, 2);
    do_req("lw20_keep", 0, 3'b010, 32'h20, 32'h0, 32'h00008000, 0, 2);

`ifdef DATA_MEM_MISALIGN_SPLIT_EN
    do_req("sw0d", 1, 3'b010, 32'h0D, 32'h11223344, 32'h0, 0, 3);
    do_req("lw0d", 0, 3'b010, 32'h0D, 32'h0, 32'h11223344, 0, 3);
    do_req("lbu10", 0, 3'b100, 32'h10, 32'h0, 32'h00000011, 0, 2);
    do_req("lw10b", 0, 3'b010, 32'h10, 32'h0, 32'hDEADBE11, 0, 2);
    do_req("lh0f", 0, 3'b001, 32'h0F, 32'h0, 32'h00001122, 0, 3);
    do_req("lh21", 0, 3'b001, 32'h21, 32'h0, 32'h00000080, 0, 2);
`else
    do_req("lw0d_err", 0, 3'b010, 32'h0D, 32'h0, 32'h0, 1, 2);
    do_req("lh21_err", 0, 3'b001, 32'h21, 32'h0, 32'h0, 1, 2);
`endif

    // wrap-around
    do_req("swfc", 1, 3'b010, 32'hFC, 32'h0, 32'h0, 0, 2);
    do_req("sw100", 1, 3'b010, 32'h100, 32'hA5A5A5A5, 32'h0, 0, 2);
    do_req("lw000", 0, 3'b010, 32'h000, 32'h0, 32'hA5A5A5A5, 0, 2);
`ifdef DATA_MEM_MISALIGN_SPLIT_EN
    do_req("swfe", 1, 3'b010, 32'hFE, 32'h0BADF00D, 32'h0, 0, 3);
    do_req("lw000b", 0, 3'b010, 32'h000, 32'h0, 32'hA5A50BAD, 0, 2);
    do_req("lwfc", 0, 3'b010, 32'hFC, 32'h0, 32'hF00D0000, 0, 2);
`else
    do_req("swfe_err", 1, 3'b010, 32'hFE, 32'h0BADF00D, 32'h0, 1, 2);
    do_req("sh03_err", 1, 3'b001, 32'h03, 32'h00001234, 32'h0, 1, 2);
    do_req("lw000b", 0, 3'b010, 32'h000, 32'h0, 32'hA5A5A5A5, 0, 2);
    do_req("lwfc", 0, 3'b010, 32'hFC, 32'h0, 32'h0, 0, 2);
`endif

    // reset in the middle of a store
    do_req("sw40", 1, 3'b010, 32'h40, 32'h0, 32'h0, 0, 2);
    do_req("sw44", 1, 3'b010, 32'h44, 32'h0, 32'h0, 0, 2);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_func3 = 3'b010; req_wdata = 32'h55667788;
`ifdef DATA_MEM_MISALIGN_SPLIT_EN
    req_addr = 32'h41;
`else
    req_addr = 32'h40;
`endif
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("mid_ready", req_ready, 1'b1);
    @(posedge clk);
    #1 req_valid = 1'b0;
`ifdef DATA_MEM_MISALIGN_SPLIT_EN
    @(posedge clk);
    #1;
`endif
    rst = 1'b1;
    #1;
    chk("mid_rst_rvalid", resp_valid, 1'b0);
    chk("mid_rst_ready", req_ready, 1'b0);
    @(negedge clk);
    chk("mid_rst_rdata", resp_rdata, 32'h0);
    chk("mid_rst_err", resp_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_ready_after", req_ready, 1'b1);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid === 1'b1) seen = 1'b1;
    end
    chk("mid_no_resp", seen, 1'b0);
`ifdef DATA_MEM_MISALIGN_SPLIT_EN
    mdl[8'h41] = 8'h88; mdl[8'h42] = 8'h77; mdl[8'h43] = 8'h66;
    do_req("lw40_mid", 0, 3'b010, 32'h40, 32'h0, 32'h66778800, 0, 2);
`else
    do_req("lw40_mid", 0, 3'b010, 32'h40, 32'h0, 32'h0, 0, 2);
`endif
    do_req("lw44_mid", 0, 3'b010, 32'h44, 32'h0, 32'h0, 0, 2);

    // randomized mix against the reference memory
    for (int i = 0; i < 30; i++) begin
      f3 = f3_tab[$urandom_range(0, 9)];
      we = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 1023));
      wd = $urandom;
      mdl_expect(we, f3, a[7:0], er, ee, el);
      do_req($sformatf("rnd%0d", i), we, f3, a, wd, er, ee, el);
    end

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
